// File: rtl/uart_alu_host.sv
// Host-side command engine: pops (opcode, A, B) frames from the rx FIFO,
// runs a small ALU and pushes the one-byte result into the tx FIFO.
module uart_alu_host #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned TIMEOUT = 1_000_000,
    parameter int unsigned TO_W    = 20
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_rx_empty,
    input  logic [DBIT-1:0] i_r_data,
    output logic            o_rd_uart,
    input  logic            i_tx_full,
    output logic            o_wr_uart,
    output logic [DBIT-1:0] o_w_data,
    output logic [DBIT-1:0] o_result,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err
);

    localparam logic [DBIT-1:0] OP_ADD = DBIT'(8'h20);
    localparam logic [DBIT-1:0] OP_SUB = DBIT'(8'h22);
    localparam logic [DBIT-1:0] OP_AND = DBIT'(8'h24);
    localparam logic [DBIT-1:0] OP_OR  = DBIT'(8'h25);
    localparam logic [DBIT-1:0] OP_XOR = DBIT'(8'h26);
    localparam logic [DBIT-1:0] OP_NOR = DBIT'(8'h27);
    localparam logic [DBIT-1:0] OP_SRL = DBIT'(8'h02);
    localparam logic [DBIT-1:0] OP_SRA = DBIT'(8'h03);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GET_A = 3'd1,
        S_GET_B = 3'd2,
        S_EXEC  = 3'd3,
        S_SEND  = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [DBIT-1:0]   op_q, op_d;
    logic [DBIT-1:0]   a_q, a_d;
    logic [DBIT-1:0]   b_q, b_d;
    logic [DBIT-1:0]   result_q, result_d;
    logic [DBIT-1:0]   w_data_q, w_data_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    logic              pop_ok;
    logic [TO_W-1:0]   cnt_inc;
    logic              shift_big;
    logic [DBIT-1:0]   sra_res;
    logic [DBIT-1:0]   alu_res;

    function automatic logic op_valid(input logic [DBIT-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRL, OP_SRA: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    // ALU on the latched operands; shifts of DBIT or more saturate
    always_comb begin
        shift_big = (32'(b_q) >= DBIT);
        sra_res   = $signed(a_q) >>> b_q;
        alu_res   = '0;
        case (op_q)
            OP_ADD:  alu_res = a_q + b_q;
            OP_SUB:  alu_res = a_q - b_q;
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_NOR:  alu_res = ~(a_q | b_q);
            OP_SRL:  alu_res = shift_big ? '0 : (a_q >> b_q);
            OP_SRA:  alu_res = shift_big ? {DBIT{a_q[DBIT-1]}} : sra_res;
            default: alu_res = '0;
        endcase
    end

    // The pop strobe is registered, so the FIFO head only advances one cycle
    // after the strobe; skip the flag check on that cycle to avoid a stale read.
    assign pop_ok  = !i_rx_empty && !rd_q;
    assign cnt_inc = cnt_q + TO_W'(1);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        w_data_d = w_data_q;
        cnt_d    = cnt_q;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (pop_ok) begin
                    rd_d = 1'b1;
                    op_d = i_r_data;
                    if (op_valid(i_r_data)) begin
                        state_d = S_GET_A;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_GET_A, S_GET_B: begin
                if (pop_ok) begin
                    rd_d  = 1'b1;
                    cnt_d = '0;
                    if (state_q == S_GET_A) begin
                        a_d     = i_r_data;
                        state_d = S_GET_B;
                    end else begin
                        b_d     = i_r_data;
                        state_d = S_EXEC;
                    end
                end else if (i_rx_empty) begin
                    if (cnt_inc == TO_W'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_EXEC: begin
                result_d = alu_res;
                state_d  = S_SEND;
            end
            S_SEND: begin
                if (!i_tx_full) begin
                    wr_d     = 1'b1;
                    done_d   = 1'b1;
                    w_data_d = result_q;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            w_data_q <= '0;
            cnt_q    <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            w_data_q <= w_data_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign o_rd_uart = rd_q;
    assign o_wr_uart = wr_q;
    assign o_w_data  = w_data_q;
    assign o_result  = result_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_err     = err_q;

endmodule

// File: tb/tb_uart_alu_host.sv
// Directed bench for uart_alu_host: FWFT rx FIFO model, pulse monitor,
// table-driven ALU vectors and hand-written multi-cycle corner sequences.
module tb_uart_alu_host;

    localparam int unsigned TB_TIMEOUT = 16;
    localparam int unsigned TB_TO_W    = 5;

    logic       clk = 1'b0;
    logic       i_reset;
    logic       i_rx_empty = 1'b1;
    logic [7:0] i_r_data   = 8'h00;
    logic       i_tx_full;
    logic       o_rd_uart, o_wr_uart, o_busy, o_done, o_err;
    logic [7:0] o_w_data, o_result;

    uart_alu_host #(.DBIT(8), .TIMEOUT(TB_TIMEOUT), .TO_W(TB_TO_W)) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_rx_empty (i_rx_empty),
        .i_r_data   (i_r_data),
        .o_rd_uart  (o_rd_uart),
        .i_tx_full  (i_tx_full),
        .o_wr_uart  (o_wr_uart),
        .o_w_data   (o_w_data),
        .o_result   (o_result),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err)
    );

    always #5 clk = ~clk;

    // rx FIFO model: main writes rx_mem/wr_ptr, this block owns rd_ptr and flags
    logic [7:0] rx_mem [256];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    logic       fifo_pop;
    assign fifo_pop = o_rd_uart && !i_rx_empty;

    always @(posedge clk) begin
        if (fifo_pop) rd_ptr <= rd_ptr + 8'd1;
        i_rx_empty <= (8'(rd_ptr + {7'd0, fifo_pop}) == wr_ptr);
        i_r_data   <= rx_mem[8'(rd_ptr + {7'd0, fifo_pop})];
    end

    // Pulse monitor sampled on the falling edge
    int         cyc = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0, err_cnt = 0;
    int         last_rd_cyc = 0, last_wr_cyc = 0, last_err_cyc = 0;
    logic [7:0] last_wr_data = 8'h00;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (o_rd_uart) begin
            rd_cnt      <= rd_cnt + 1;
            last_rd_cyc <= cyc;
        end
        if (o_wr_uart) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_cyc  <= cyc;
            last_wr_data <= o_w_data;
        end
        if (o_done) done_cnt <= done_cnt + 1;
        if (o_err) begin
            err_cnt      <= err_cnt + 1;
            last_err_cyc <= cyc;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_mem[wr_ptr] = b;
        wr_ptr         = wr_ptr + 8'd1;
    endtask

    task automatic wait_wr(input int base, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (wr_cnt != base) break;
            tick();
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({o_busy, o_rd_uart, o_wr_uart, o_done, o_err, o_result, o_w_data});
    endfunction

    task automatic run_frame(input string name, input logic [7:0] op, input logic [7:0] a,
                             input logic [7:0] b, input logic [7:0] exp);
        int rd0, wr0, done0, err0;
        rd0 = rd_cnt; wr0 = wr_cnt; done0 = done_cnt; err0 = err_cnt;
        push_byte(op); push_byte(a); push_byte(b);
        wait_wr(wr0, 60);
        tick(); tick();
        check({name, " w_data"},  32'(last_wr_data), 32'(exp));
        check({name, " result"},  32'(o_result), 32'(exp));
        check({name, " pops"},    32'(rd_cnt - rd0), 32'd3);
        check({name, " pushes"},  32'(wr_cnt - wr0), 32'd1);
        check({name, " done"},    32'(done_cnt - done0), 32'd1);
        check({name, " err"},     32'(err_cnt - err0), 32'd0);
        check({name, " latency"}, 32'(last_wr_cyc - last_rd_cyc), 32'd2);
        check({name, " busy"},    32'(o_busy), 32'd0);
    endtask

    typedef struct {
        string      name;
        logic [7:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int rd0, wr0, err0, done0, a_cyc;

        vecs[0]  = '{"add",       8'h20, 8'h05, 8'h03, 8'h08};
        vecs[1]  = '{"sub",       8'h22, 8'h03, 8'h05, 8'hFE};
        vecs[2]  = '{"sra2",      8'h03, 8'h80, 8'h02, 8'hE0};
        vecs[3]  = '{"srl9",      8'h02, 8'h80, 8'h09, 8'h00};
        vecs[4]  = '{"nor",       8'h27, 8'hF0, 8'h0F, 8'h00};
        vecs[5]  = '{"and",       8'h24, 8'hCC, 8'hAA, 8'h88};
        vecs[6]  = '{"or",        8'h25, 8'h11, 8'h22, 8'h33};
        vecs[7]  = '{"xor",       8'h26, 8'hFF, 8'h0F, 8'hF0};
        vecs[8]  = '{"sra9",      8'h03, 8'h80, 8'h09, 8'hFF};
        vecs[9]  = '{"srl4",      8'h02, 8'hF0, 8'h04, 8'h0F};
        vecs[10] = '{"sra8_pos",  8'h03, 8'h7F, 8'h08, 8'h00};
        vecs[11] = '{"add_wrap",  8'h20, 8'hFF, 8'h02, 8'h01};
        vecs[12] = '{"sra7",      8'h03, 8'hC0, 8'h07, 8'hFF};
        vecs[13] = '{"srl7",      8'h02, 8'h81, 8'h07, 8'h01};

        i_reset   = 1'b0;
        i_tx_full = 1'b0;
        repeat (3) tick();
        check("reset outputs", outs(), 32'd0);
        i_reset = 1'b1;
        tick(); tick();
        check("idle after reset", outs(), 32'd0);

        foreach (vecs[i]) begin
            run_frame(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Invalid opcode followed by a valid frame
        rd0 = rd_cnt; wr0 = wr_cnt; err0 = err_cnt; done0 = done_cnt;
        push_byte(8'h55); push_byte(8'h24); push_byte(8'hCC); push_byte(8'hAA);
        wait_wr(wr0, 80);
        repeat (3) tick();
        check("badop err",     32'(err_cnt - err0), 32'd1);
        check("badop pushes",  32'(wr_cnt - wr0), 32'd1);
        check("badop data",    32'(last_wr_data), 32'h88);
        check("badop pops",    32'(rd_cnt - rd0), 32'd4);
        check("badop done",    32'(done_cnt - done0), 32'd1);
        check("badop order",   32'(last_err_cyc < last_wr_cyc), 32'd1);

        // Timeout after opcode + A with rx held empty
        rd0 = rd_cnt; wr0 = wr_cnt; err0 = err_cnt;
        push_byte(8'h25); push_byte(8'h11);
        for (int i = 0; i < 20 && rd_cnt != rd0 + 2; i++) tick();
        a_cyc = last_rd_cyc;
        for (int i = 0; i < 40 && err_cnt == err0; i++) tick();
        tick();
        check("timeout err",    32'(err_cnt - err0), 32'd1);
        check("timeout delay",  32'(last_err_cyc - a_cyc), 32'(TB_TIMEOUT));
        check("timeout busy",   32'(o_busy), 32'd0);
        check("timeout pushes", 32'(wr_cnt - wr0), 32'd0);
        run_frame("to_recover", 8'h25, 8'h11, 8'h22, 8'h33);

        // tx FIFO full holds the response in SEND
        i_tx_full = 1'b1;
        wr0 = wr_cnt;
        push_byte(8'h20); push_byte(8'h7F); push_byte(8'h01);
        repeat (50) tick();
        check("txfull no push", 32'(wr_cnt - wr0), 32'd0);
        check("txfull busy",    32'(o_busy), 32'd1);
        i_tx_full = 1'b0;
        tick();
        check("txfull release wr",   32'(o_wr_uart), 32'd1);
        check("txfull release data", 32'(o_w_data), 32'h80);
        check("txfull release done", 32'(o_done), 32'd1);
        tick();
        check("txfull single push",  32'(wr_cnt - wr0), 32'd1);
        check("txfull wr low",       32'(o_wr_uart), 32'd0);

        // Asynchronous reset mid-frame
        rd0 = rd_cnt;
        push_byte(8'h26); push_byte(8'hFF);
        for (int i = 0; i < 20 && rd_cnt != rd0 + 2; i++) tick();
        tick();
        check("pre-reset busy", 32'(o_busy), 32'd1);
        i_reset = 1'b0;
        #1;
        check("midframe reset outputs", outs(), 32'd0);
        rd0 = rd_cnt;
        tick(); tick();
        check("no pop in reset", 32'(rd_cnt - rd0), 32'd0);
        i_reset = 1'b1;
        tick();
        run_frame("rst_xor", 8'h26, 8'hFF, 8'h0F, 8'hF0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
